ps2_text_writer: RTL and testbench

- Input-side counterpart to the VGA text display path.
- Receives PS/2 keyboard frames, decodes make codes (scan-code set 2) to ASCII, and writes characters into the shared 704-byte text buffer at a cursor.
- The same buffer is read by the VGA renderer.
- Sits beside Character_manager on clk3 and owns the buffer write port.

---
 rtl/ps2_text_writer.sv | 232 +++++++++++++++++++++++
 tb/tb_ps2_text_writer.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_text_writer.sv
// PS/2 keyboard receiver and scan-code-set-2 decoder that types ASCII characters
// into the shared text buffer at a cursor, owning the buffer write port.
module ps2_text_writer #(
    parameter int COLS    = 32,
    parameter int ROWS    = 22,
    parameter int TIMEOUT = 4000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       wr_en,
    output logic [9:0] wr_addr,
    output logic [7:0] wr_data,
    output logic [9:0] cursor,
    output logic       frame_err,
    output logic [1:0] rx_state
);

    localparam int         DEPTH = COLS * ROWS;
    localparam logic [9:0] LAST  = 10'(DEPTH - 1);
    localparam int         TW    = $clog2(TIMEOUT + 1);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SHIFT  = 2'd1;
    localparam logic [1:0] PARITY = 2'd2;
    localparam logic [1:0] STOP   = 2'd3;

    localparam logic [1:0] K_NONE  = 2'd0;
    localparam logic [1:0] K_CHAR  = 2'd1;
    localparam logic [1:0] K_ENTER = 2'd2;
    localparam logic [1:0] K_BS    = 2'd3;

    // Synchronisers reset to the idle-high line level so reset release never
    // looks like a falling edge.
    logic [2:0] clk_s_q;
    logic [1:0] data_s_q;
    logic       fall;
    logic       bit_in;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            clk_s_q  <= 3'b111;
            data_s_q <= 2'b11;
        end else begin
            clk_s_q  <= {clk_s_q[1:0], ps2_clk};
            data_s_q <= {data_s_q[0], ps2_data};
        end
    end

    assign fall   = clk_s_q[2] & ~clk_s_q[1];
    assign bit_in = data_s_q[1];

    logic [1:0]    state_q, state_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic          parity_q, parity_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          byte_valid_q, byte_valid_d;
    logic          rx_err_q, rx_err_d;

    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        parity_d     = parity_q;
        byte_valid_d = 1'b0;
        rx_err_d     = 1'b0;
        if (fall || state_q == IDLE) tmo_d = '0;
        else                         tmo_d = tmo_q + 1'b1;

        if (fall) begin
            case (state_q)
                IDLE: begin
                    if (!bit_in) begin
                        state_d   = SHIFT;
                        bit_cnt_d = 3'd0;
                    end
                end
                SHIFT: begin
                    shift_d   = {bit_in, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) state_d = PARITY;
                end
                PARITY: begin
                    parity_d = bit_in;
                    state_d  = STOP;
                end
                default: begin
                    if (bit_in && (^{shift_q, parity_q})) byte_valid_d = 1'b1;
                    else                                  rx_err_d     = 1'b1;
                    state_d = IDLE;
                end
            endcase
        end else if (state_q != IDLE && tmo_q == TW'(TIMEOUT - 1)) begin
            // TIMEOUT cycles since the last edge: abandon the partial frame.
            rx_err_d = 1'b1;
            state_d  = IDLE;
            tmo_d    = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            bit_cnt_q    <= 3'd0;
            shift_q      <= 8'd0;
            parity_q     <= 1'b0;
            tmo_q        <= '0;
            byte_valid_q <= 1'b0;
            rx_err_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            parity_q     <= parity_d;
            tmo_q        <= tmo_d;
            byte_valid_q <= byte_valid_d;
            rx_err_q     <= rx_err_d;
        end
    end

    // Returns {kind, ascii} for a make code.
    function automatic logic [9:0] decode_key(input logic [7:0] code);
        logic [9:0] r;
        r = {K_NONE, 8'h00};
        case (code)
            8'h1C: r = {K_CHAR, 8'h41}; 8'h32: r = {K_CHAR, 8'h42};
            8'h21: r = {K_CHAR, 8'h43}; 8'h23: r = {K_CHAR, 8'h44};
            8'h24: r = {K_CHAR, 8'h45}; 8'h2B: r = {K_CHAR, 8'h46};
            8'h34: r = {K_CHAR, 8'h47}; 8'h33: r = {K_CHAR, 8'h48};
            8'h43: r = {K_CHAR, 8'h49}; 8'h3B: r = {K_CHAR, 8'h4A};
            8'h42: r = {K_CHAR, 8'h4B}; 8'h4B: r = {K_CHAR, 8'h4C};
            8'h3A: r = {K_CHAR, 8'h4D}; 8'h31: r = {K_CHAR, 8'h4E};
            8'h44: r = {K_CHAR, 8'h4F}; 8'h4D: r = {K_CHAR, 8'h50};
            8'h15: r = {K_CHAR, 8'h51}; 8'h2D: r = {K_CHAR, 8'h52};
            8'h1B: r = {K_CHAR, 8'h53}; 8'h2C: r = {K_CHAR, 8'h54};
            8'h3C: r = {K_CHAR, 8'h55}; 8'h2A: r = {K_CHAR, 8'h56};
            8'h1D: r = {K_CHAR, 8'h57}; 8'h22: r = {K_CHAR, 8'h58};
            8'h35: r = {K_CHAR, 8'h59}; 8'h1A: r = {K_CHAR, 8'h5A};
            8'h45: r = {K_CHAR, 8'h30}; 8'h16: r = {K_CHAR, 8'h31};
            8'h1E: r = {K_CHAR, 8'h32}; 8'h26: r = {K_CHAR, 8'h33};
            8'h25: r = {K_CHAR, 8'h34}; 8'h2E: r = {K_CHAR, 8'h35};
            8'h36: r = {K_CHAR, 8'h36}; 8'h3D: r = {K_CHAR, 8'h37};
            8'h3E: r = {K_CHAR, 8'h38}; 8'h46: r = {K_CHAR, 8'h39};
            8'h29: r = {K_CHAR, 8'h20};
            8'h5A: r = {K_ENTER, 8'h00};
            8'h66: r = {K_BS, 8'h00};
            default: r = {K_NONE, 8'h00};
        endcase
        return r;
    endfunction

    logic       brk_q, brk_d;
    logic       ext_q, ext_d;
    logic       wr_en_q, wr_en_d;
    logic [9:0] wr_addr_q, wr_addr_d;
    logic [7:0] wr_data_q, wr_data_d;
    logic [9:0] cursor_q, cursor_d;
    logic [9:0] key;
    logic [9:0] row;

    assign key = decode_key(shift_q);
    assign row = cursor_q / 10'(COLS);

    always_comb begin
        brk_d     = brk_q;
        ext_d     = ext_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        cursor_d  = cursor_q;
        if (byte_valid_q) begin
            if (shift_q == 8'hF0) begin
                brk_d = 1'b1;
            end else if (shift_q == 8'hE0) begin
                ext_d = 1'b1;
            end else if (brk_q || ext_q) begin
                brk_d = 1'b0;
                ext_d = 1'b0;
            end else begin
                case (key[9:8])
                    K_CHAR: begin
                        wr_en_d   = 1'b1;
                        wr_addr_d = cursor_q;
                        wr_data_d = key[7:0];
                        cursor_d  = (cursor_q == LAST) ? 10'd0 : cursor_q + 10'd1;
                    end
                    K_ENTER: begin
                        cursor_d = (row == 10'(ROWS - 1)) ? 10'd0
                                                          : (row + 10'd1) * 10'(COLS);
                    end
                    K_BS: begin
                        if (cursor_q != 10'd0) begin
                            wr_en_d   = 1'b1;
                            wr_addr_d = cursor_q - 10'd1;
                            wr_data_d = 8'h20;
                            cursor_d  = cursor_q - 10'd1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            brk_q     <= 1'b0;
            ext_q     <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= 10'd0;
            wr_data_q <= 8'd0;
            cursor_q  <= 10'd0;
        end else begin
            brk_q     <= brk_d;
            ext_q     <= ext_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            cursor_q  <= cursor_d;
        end
    end

    assign wr_en     = wr_en_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;
    assign cursor    = cursor_q;
    assign frame_err = rx_err_q;
    assign rx_state  = state_q;

endmodule

// File: tb/tb_ps2_text_writer.sv
// Self-checking bench for ps2_text_writer: drives PS/2 frames and scoreboards
// buffer writes, cursor movement and frame errors.
module tb_ps2_text_writer;
  localparam int HALF    = 8;
  localparam int TIMEOUT = 4000;

  logic       clk;
  logic       reset;
  logic       ps2_clk;
  logic       ps2_data;
  logic       wr_en;
  logic [9:0] wr_addr;
  logic [7:0] wr_data;
  logic [9:0] cursor;
  logic       frame_err;
  logic [1:0] rx_state;

  ps2_text_writer #(.COLS(32), .ROWS(22), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .cursor(cursor),
    .frame_err(frame_err), .rx_state(rx_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int err_seen = 0;
  int exp_cursor = 0;
  logic [17:0] exp_q[$];

  // scoreboard: every write strobe pops one expected {addr, data}
  always @(negedge clk) begin
    logic [17:0] e;
    if (frame_err) err_seen++;
    if (wr_en) begin
      n_cmp++;
      if (frame_err !== 1'b0) begin
        n_err++;
        $display("FAIL overlap: frame_err=%b with wr_en, required 0", frame_err);
      end
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_write: addr=%0d data=%h, required no write", wr_addr, wr_data);
      end else begin
        e = exp_q.pop_front();
        if ({wr_addr, wr_data} !== e) begin
          n_err++;
          $display("FAIL write: addr=%0d data=%h, required addr=%0d data=%h",
                   wr_addr, wr_data, e[17:8], e[7:0]);
        end
      end
    end
  end

  // driver tasks
  task automatic ps2_bit(input logic b);
    ps2_data = b;
    repeat (HALF) @(posedge clk);
    ps2_clk = 1'b0;
    repeat (HALF) @(posedge clk);
    ps2_clk = 1'b1;
  endtask

  task automatic send_raw(input logic [7:0] code, input logic par, input logic stop);
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(code[i]);
    ps2_bit(par);
    ps2_bit(stop);
    ps2_data = 1'b1;
    repeat (12) @(posedge clk);
  endtask

  task automatic send_frame(input logic [7:0] code);
    send_raw(code, ~^code, 1'b1);
  endtask

  task automatic key_char(input logic [7:0] code, input logic [7:0] ascii);
    exp_q.push_back({10'(exp_cursor), ascii});
    exp_cursor = (exp_cursor == 703) ? 0 : exp_cursor + 1;
    send_frame(code);
  endtask

  task automatic key_enter();
    exp_cursor = ((exp_cursor / 32) == 21) ? 0 : ((exp_cursor / 32) + 1) * 32;
    send_frame(8'h5A);
  endtask

  task automatic key_bs();
    if (exp_cursor != 0) begin
      exp_cursor = exp_cursor - 1;
      exp_q.push_back({10'(exp_cursor), 8'h20});
    end
    send_frame(8'h66);
  endtask

  // tests
  task automatic test_reset();
    reset = 1'b0;
    ps2_clk = 1'b1;
    ps2_data = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    n_cmp++;
    if ({wr_en, wr_addr, wr_data, cursor, frame_err, rx_state} !== 31'd0) begin
      n_err++;
      $display("FAIL reset_outputs: en=%b addr=%0d data=%h cur=%0d err=%b st=%0d, required all 0",
               wr_en, wr_addr, wr_data, cursor, frame_err, rx_state);
    end
    @(negedge clk) reset = 1'b1;
    repeat (4) @(posedge clk);
  endtask

  task automatic test_char();
    key_char(8'h1C, 8'h41);
    n_cmp++;
    if (cursor !== 10'(exp_cursor) || exp_cursor != 1) begin
      n_err++;
      $display("FAIL char_cursor: cursor=%0d, required 1", cursor);
    end
  endtask

  task automatic test_break();
    key_char(8'h16, 8'h31);
    send_frame(8'hF0);
    send_frame(8'h16);
    send_frame(8'hE0);
    send_frame(8'h75);
    send_frame(8'h0E);
    n_cmp++;
    if (cursor !== 10'(exp_cursor)) begin
      n_err++;
      $display("FAIL break_cursor: cursor=%0d, required %0d", cursor, exp_cursor);
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL break_pending: %0d writes missing, required 0", exp_q.size());
    end
  endtask

  task automatic test_backspace();
    key_char(8'h1E, 8'h32);
    key_char(8'h26, 8'h33);
    key_char(8'h25, 8'h34);
    n_cmp++;
    if (cursor !== 10'd5) begin
      n_err++;
      $display("FAIL bs_setup: cursor=%0d, required 5", cursor);
    end
    key_bs();
    n_cmp++;
    if (cursor !== 10'd4) begin
      n_err++;
      $display("FAIL bs_cursor: cursor=%0d, required 4", cursor);
    end
    repeat (4) key_bs();
    key_bs();
    n_cmp++;
    if (cursor !== 10'd0) begin
      n_err++;
      $display("FAIL bs_at_zero: cursor=%0d, required 0", cursor);
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL bs_pending: %0d writes missing, required 0", exp_q.size());
    end
  endtask

  task automatic test_enter();
    key_enter();
    for (int i = 0; i < 8; i++) key_char(8'h3D, 8'h37);
    n_cmp++;
    if (cursor !== 10'd40) begin
      n_err++;
      $display("FAIL enter_setup: cursor=%0d, required 40", cursor);
    end
    key_enter();
    n_cmp++;
    if (cursor !== 10'd64) begin
      n_err++;
      $display("FAIL enter_cursor: cursor=%0d, required 64", cursor);
    end
  endtask

  task automatic test_wrap();
    repeat (19) key_enter();
    for (int i = 0; i < 31; i++) key_char(8'h1C, 8'h41);
    n_cmp++;
    if (cursor !== 10'd703) begin
      n_err++;
      $display("FAIL wrap_setup: cursor=%0d, required 703", cursor);
    end
    key_char(8'h29, 8'h20);
    n_cmp++;
    if (cursor !== 10'd0) begin
      n_err++;
      $display("FAIL wrap_char: cursor=%0d, required 0", cursor);
    end
    repeat (21) key_enter();
    n_cmp++;
    if (cursor !== 10'd672) begin
      n_err++;
      $display("FAIL wrap_lastrow: cursor=%0d, required 672", cursor);
    end
    key_enter();
    n_cmp++;
    if (cursor !== 10'd0) begin
      n_err++;
      $display("FAIL wrap_enter: cursor=%0d, required 0", cursor);
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL wrap_pending: %0d writes missing, required 0", exp_q.size());
    end
  endtask

  task automatic test_frame_err();
    int e0;
    e0 = err_seen;
    send_raw(8'h1C, 1'b1, 1'b1);
    n_cmp++;
    if (err_seen - e0 != 1) begin
      n_err++;
      $display("FAIL parity_err: pulses=%0d, required 1", err_seen - e0);
    end
    send_raw(8'h1C, 1'b0, 1'b0);
    n_cmp++;
    if (err_seen - e0 != 2) begin
      n_err++;
      $display("FAIL stop_err: pulses=%0d, required 2", err_seen - e0);
    end
    n_cmp++;
    if (cursor !== 10'(exp_cursor)) begin
      n_err++;
      $display("FAIL err_cursor: cursor=%0d, required %0d", cursor, exp_cursor);
    end
  endtask

  task automatic test_timeout();
    int e0;
    e0 = err_seen;
    ps2_bit(1'b0);
    for (int i = 0; i < 4; i++) ps2_bit(1'b1);
    ps2_data = 1'b1;
    repeat (TIMEOUT + 100) @(posedge clk);
    n_cmp++;
    if (err_seen - e0 != 1 || rx_state !== 2'd0) begin
      n_err++;
      $display("FAIL timeout: pulses=%0d state=%0d, required 1 and 0", err_seen - e0, rx_state);
    end
    key_char(8'h32, 8'h42);
    n_cmp++;
    if (cursor !== 10'(exp_cursor) || exp_q.size() != 0) begin
      n_err++;
      $display("FAIL timeout_recover: cursor=%0d pending=%0d, required %0d and 0",
               cursor, exp_q.size(), exp_cursor);
    end
  endtask

  task automatic test_reset_mid();
    int e0;
    e0 = err_seen;
    ps2_bit(1'b0);
    for (int i = 0; i < 4; i++) ps2_bit(i[0]);
    @(negedge clk) reset = 1'b0;
    ps2_clk = 1'b1;
    ps2_data = 1'b1;
    #1;
    n_cmp++;
    if ({wr_en, wr_addr, wr_data, cursor, frame_err, rx_state} !== 31'd0) begin
      n_err++;
      $display("FAIL mid_reset: en=%b addr=%0d data=%h cur=%0d err=%b st=%0d, required all 0",
               wr_en, wr_addr, wr_data, cursor, frame_err, rx_state);
    end
    repeat (3) @(posedge clk);
    @(negedge clk) reset = 1'b1;
    exp_cursor = 0;
    repeat (TIMEOUT + 50) @(posedge clk);
    key_char(8'h24, 8'h45);
    n_cmp++;
    if (cursor !== 10'd1 || err_seen != e0 || exp_q.size() != 0) begin
      n_err++;
      $display("FAIL mid_reset_after: cursor=%0d errs=%0d pending=%0d, required 1, 0, 0",
               cursor, err_seen - e0, exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_char();
    test_break();
    test_backspace();
    test_enter();
    test_wrap();
    test_frame_err();
    test_timeout();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
